// File: rtl/noc_rsc_packetizer.sv
// Resource-side NoC transmitter: packet request + payload stream -> HEAD/BODY/TAIL flits.
// Optional flit/packet handshake counters are built in when NOC_PKTZ_STATS_EN is defined.
//
// state     | meaning
// S_IDLE    | waiting for a packet request; HEAD is emitted on handshake
// S_PAYLOAD | forwarding payload words; last word goes out as TAIL
// S_ZTAIL   | zero-length packet; emit a data-less TAIL
module noc_rsc_packetizer #(
  parameter int ROW_N     = 3,
  parameter int COL_M     = 3,
  parameter int CHANNEL_W = 8,
  parameter int FLIT_ID_W = 2,
  parameter int LEN_W     = 4,
  localparam int ROW_ADDR_W  = $clog2(ROW_N),
  localparam int COL_ADDR_W  = $clog2(COL_M),
  localparam int FLIT_DATA_W = CHANNEL_W - FLIT_ID_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [ROW_ADDR_W-1:0]  pkt_dst_row_i,
  input  logic [COL_ADDR_W-1:0]  pkt_dst_col_i,
  input  logic [LEN_W-1:0]       pkt_len_i,
  input  logic                   pkt_vld_i,
  output logic                   pkt_rdy_o,
  input  logic [FLIT_DATA_W-1:0] pl_data_i,
  input  logic                   pl_vld_i,
  output logic                   pl_rdy_o,
  output logic [CHANNEL_W-1:0]   flit_data_o,
  output logic                   flit_vld_o,
  input  logic                   flit_rdy_i
`ifdef NOC_PKTZ_STATS_EN
  ,
  output logic [15:0]            pkt_cnt_o,
  output logic [15:0]            flit_cnt_o
`endif
);

  localparam logic [FLIT_ID_W-1:0] ID_HEAD = FLIT_ID_W'(1);
  localparam logic [FLIT_ID_W-1:0] ID_BODY = FLIT_ID_W'(2);
  localparam logic [FLIT_ID_W-1:0] ID_TAIL = FLIT_ID_W'(3);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_ZTAIL} state_t;

  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic                   free;
  logic                   load;
  logic [CHANNEL_W-1:0]   load_data;
  logic [FLIT_DATA_W-1:0] head_data;
  logic                   last_word;

  assign free      = !flit_vld_o || flit_rdy_i;
  assign last_word = (rem_q == LEN_W'(1));

  always_comb begin
    head_data = '0;
    head_data[COL_ADDR_W-1:0]          = pkt_dst_col_i;
    head_data[COL_ADDR_W +: ROW_ADDR_W] = pkt_dst_row_i;
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    load      = 1'b0;
    load_data = '0;
    pkt_rdy_o = 1'b0;
    pl_rdy_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        pkt_rdy_o = free;
        if (pkt_vld_i && free) begin
          load      = 1'b1;
          load_data = {ID_HEAD, head_data};
          if (pkt_len_i == '0) begin
            state_d = S_ZTAIL;
          end else begin
            rem_d   = pkt_len_i;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        pl_rdy_o = free;
        if (pl_vld_i && free) begin
          load      = 1'b1;
          load_data = {(last_word ? ID_TAIL : ID_BODY), pl_data_i};
          rem_d     = rem_q - LEN_W'(1);
          if (last_word) state_d = S_IDLE;
        end
      end
      S_ZTAIL: begin
        if (free) begin
          load      = 1'b1;
          load_data = {ID_TAIL, {FLIT_DATA_W{1'b0}}};
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      flit_vld_o  <= 1'b0;
      flit_data_o <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      // a load wins over a drain so a consumed register refills in the same cycle
      if (load) begin
        flit_vld_o  <= 1'b1;
        flit_data_o <= load_data;
      end else if (flit_rdy_i) begin
        flit_vld_o  <= 1'b0;
      end
    end
  end

`ifdef NOC_PKTZ_STATS_EN
  logic fire;
  assign fire = flit_vld_o && flit_rdy_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_cnt_o  <= '0;
      flit_cnt_o <= '0;
    end else if (fire) begin
      flit_cnt_o <= flit_cnt_o + 16'd1;
      if (flit_data_o[CHANNEL_W-1 -: FLIT_ID_W] == ID_TAIL) pkt_cnt_o <= pkt_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_rsc_packetizer.sv
// Directed self-checking bench for noc_rsc_packetizer (default geometry: 3x3 mesh, 8-bit flits).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_noc_rsc_packetizer;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [1:0] pkt_dst_row = '0;
  logic [1:0] pkt_dst_col = '0;
  logic [3:0] pkt_len = '0;
  logic       pkt_vld = 1'b0;
  logic       pkt_rdy;
  logic [5:0] pl_data = '0;
  logic       pl_vld = 1'b0;
  logic       pl_rdy;
  logic [7:0] flit_data;
  logic       flit_vld;
  logic       flit_rdy = 1'b1;
`ifdef NOC_PKTZ_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] flit_cnt;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  noc_rsc_packetizer dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .pkt_dst_row_i (pkt_dst_row),
    .pkt_dst_col_i (pkt_dst_col),
    .pkt_len_i     (pkt_len),
    .pkt_vld_i     (pkt_vld),
    .pkt_rdy_o     (pkt_rdy),
    .pl_data_i     (pl_data),
    .pl_vld_i      (pl_vld),
    .pl_rdy_o      (pl_rdy),
    .flit_data_o   (flit_data),
    .flit_vld_o    (flit_vld),
    .flit_rdy_i    (flit_rdy)
`ifdef NOC_PKTZ_STATS_EN
    ,
    .pkt_cnt_o     (pkt_cnt),
    .flit_cnt_o    (flit_cnt)
`endif
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    total_cnt++; if (flit_vld !== 1'b0) $display("FAIL reset_vld got %b exp 0", flit_vld); else pass_cnt++;
    total_cnt++; if (flit_data !== 8'h00) $display("FAIL reset_data got %h exp 00", flit_data); else pass_cnt++;
    total_cnt++; if (pkt_rdy !== 1'b1) $display("FAIL reset_pkt_rdy got %b exp 1", pkt_rdy); else pass_cnt++;
    total_cnt++; if (pl_rdy !== 1'b0) $display("FAIL reset_pl_rdy got %b exp 0", pl_rdy); else pass_cnt++;
    step(); rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    step(); pkt_dst_row = 2'd2; pkt_dst_col = 2'd1; pkt_len = 4'd2; pkt_vld = 1'b1; #1;
    total_cnt++; if (pkt_rdy !== 1'b1) $display("FAIL basic_pkt_rdy got %b exp 1", pkt_rdy); else pass_cnt++;
    step(); pkt_vld = 1'b0; pl_vld = 1'b1; pl_data = 6'h15; #1;
    total_cnt++; if ({flit_vld, flit_data} !== {1'b1, 8'h49}) $display("FAIL basic_head got %b/%h exp 1/49", flit_vld, flit_data); else pass_cnt++;
    total_cnt++; if (pl_rdy !== 1'b1) $display("FAIL basic_pl_rdy got %b exp 1", pl_rdy); else pass_cnt++;
    step(); pl_data = 6'h2A; #1;
    total_cnt++; if ({flit_vld, flit_data} !== {1'b1, 8'h95}) $display("FAIL basic_body got %b/%h exp 1/95", flit_vld, flit_data); else pass_cnt++;
    step(); pl_vld = 1'b0; #1;
    total_cnt++; if ({flit_vld, flit_data} !== {1'b1, 8'hEA}) $display("FAIL basic_tail got %b/%h exp 1/ea", flit_vld, flit_data); else pass_cnt++;
    total_cnt++; if (pkt_rdy !== 1'b1) $display("FAIL basic_idle_rdy got %b exp 1", pkt_rdy); else pass_cnt++;
    step(); #1;
    total_cnt++; if (flit_vld !== 1'b0) $display("FAIL basic_drain got %b exp 0", flit_vld); else pass_cnt++;
  endtask

  task automatic test_zero_len();
    step(); pkt_dst_row = 2'd0; pkt_dst_col = 2'd0; pkt_len = 4'd0; pkt_vld = 1'b1;
    pl_vld = 1'b1; pl_data = 6'h3F; #1;
    total_cnt++; if (pl_rdy !== 1'b0) $display("FAIL zl_pl_rdy0 got %b exp 0", pl_rdy); else pass_cnt++;
    step(); pkt_vld = 1'b0; #1;
    total_cnt++; if ({flit_vld, flit_data} !== {1'b1, 8'h40}) $display("FAIL zl_head got %b/%h exp 1/40", flit_vld, flit_data); else pass_cnt++;
    total_cnt++; if ({pkt_rdy, pl_rdy} !== 2'b00) $display("FAIL zl_rdy1 got %b exp 00", {pkt_rdy, pl_rdy}); else pass_cnt++;
    step(); #1;
    total_cnt++; if ({flit_vld, flit_data} !== {1'b1, 8'hC0}) $display("FAIL zl_tail got %b/%h exp 1/c0", flit_vld, flit_data); else pass_cnt++;
    total_cnt++; if (pl_rdy !== 1'b0) $display("FAIL zl_pl_rdy2 got %b exp 0", pl_rdy); else pass_cnt++;
    step(); #1;
    total_cnt++; if ({flit_vld, pl_rdy} !== 2'b00) $display("FAIL zl_idle got %b exp 00", {flit_vld, pl_rdy}); else pass_cnt++;
    pl_vld = 1'b0;
  endtask

  task automatic test_backpressure();
    step(); pkt_dst_row = 2'd2; pkt_dst_col = 2'd1; pkt_len = 4'd2; pkt_vld = 1'b1; flit_rdy = 1'b1;
    step(); pkt_vld = 1'b0; flit_rdy = 1'b0; pl_vld = 1'b1; pl_data = 6'h15;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if ({flit_vld, flit_data} !== {1'b1, 8'h49}) $display("FAIL bp_hold%0d got %b/%h exp 1/49", i, flit_vld, flit_data); else pass_cnt++;
      total_cnt++; if ({pkt_rdy, pl_rdy} !== 2'b00) $display("FAIL bp_rdy%0d got %b exp 00", i, {pkt_rdy, pl_rdy}); else pass_cnt++;
      step();
    end
    flit_rdy = 1'b1; #1;
    total_cnt++; if ({flit_vld, flit_data, pl_rdy} !== {1'b1, 8'h49, 1'b1}) $display("FAIL bp_release got %b/%h/%b exp 1/49/1", flit_vld, flit_data, pl_rdy); else pass_cnt++;
    step(); pl_data = 6'h2A; #1;
    total_cnt++; if ({flit_vld, flit_data} !== {1'b1, 8'h95}) $display("FAIL bp_body got %b/%h exp 1/95", flit_vld, flit_data); else pass_cnt++;
    step(); pl_vld = 1'b0; #1;
    total_cnt++; if ({flit_vld, flit_data} !== {1'b1, 8'hEA}) $display("FAIL bp_tail got %b/%h exp 1/ea", flit_vld, flit_data); else pass_cnt++;
    step(); #1;
    total_cnt++; if (flit_vld !== 1'b0) $display("FAIL bp_drain got %b exp 0", flit_vld); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    step(); pkt_dst_row = 2'd1; pkt_dst_col = 2'd2; pkt_len = 4'd1; pkt_vld = 1'b1;
    step(); pkt_dst_row = 2'd2; pkt_dst_col = 2'd0; pl_vld = 1'b1; pl_data = 6'h11; #1;
    total_cnt++; if ({flit_vld, flit_data} !== {1'b1, 8'h46}) $display("FAIL b2b_head1 got %b/%h exp 1/46", flit_vld, flit_data); else pass_cnt++;
    total_cnt++; if ({pkt_rdy, pl_rdy} !== 2'b01) $display("FAIL b2b_rdy1 got %b exp 01", {pkt_rdy, pl_rdy}); else pass_cnt++;
    step(); pl_vld = 1'b0; #1;
    total_cnt++; if ({flit_vld, flit_data} !== {1'b1, 8'hD1}) $display("FAIL b2b_tail1 got %b/%h exp 1/d1", flit_vld, flit_data); else pass_cnt++;
    total_cnt++; if (pkt_rdy !== 1'b1) $display("FAIL b2b_pkt_rdy got %b exp 1", pkt_rdy); else pass_cnt++;
    step(); pkt_vld = 1'b0; pl_vld = 1'b1; pl_data = 6'h22; #1;
    total_cnt++; if ({flit_vld, flit_data} !== {1'b1, 8'h48}) $display("FAIL b2b_head2 got %b/%h exp 1/48", flit_vld, flit_data); else pass_cnt++;
    step(); pl_vld = 1'b0; #1;
    total_cnt++; if ({flit_vld, flit_data} !== {1'b1, 8'hE2}) $display("FAIL b2b_tail2 got %b/%h exp 1/e2", flit_vld, flit_data); else pass_cnt++;
    step(); #1;
    total_cnt++; if (flit_vld !== 1'b0) $display("FAIL b2b_drain got %b exp 0", flit_vld); else pass_cnt++;
  endtask

  task automatic test_max_len();
    logic [7:0] exp_flit;
    step(); pkt_dst_row = 2'd1; pkt_dst_col = 2'd1; pkt_len = 4'd15; pkt_vld = 1'b1;
    step(); pkt_vld = 1'b0; pl_vld = 1'b1; pl_data = 6'd1; #1;
    total_cnt++; if ({flit_vld, flit_data} !== {1'b1, 8'h45}) $display("FAIL max_head got %b/%h exp 1/45", flit_vld, flit_data); else pass_cnt++;
    for (int i = 1; i <= 15; i++) begin
      step(); pl_data = 6'(i + 1);
      if (i == 15) pl_vld = 1'b0;
      #1;
      exp_flit = {(i == 15) ? 2'b11 : 2'b10, 6'(i)};
      total_cnt++; if ({flit_vld, flit_data} !== {1'b1, exp_flit}) $display("FAIL max_flit%0d got %b/%h exp 1/%h", i, flit_vld, flit_data, exp_flit); else pass_cnt++;
    end
    step(); #1;
    total_cnt++; if ({flit_vld, pkt_rdy, pl_rdy} !== 3'b010) $display("FAIL max_end got %b exp 010", {flit_vld, pkt_rdy, pl_rdy}); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    step(); pkt_dst_row = 2'd2; pkt_dst_col = 2'd1; pkt_len = 4'd3; pkt_vld = 1'b1;
    step(); pkt_vld = 1'b0; pl_vld = 1'b1; pl_data = 6'h01;
    step(); pl_vld = 1'b0; #1;
    total_cnt++; if ({flit_vld, flit_data} !== {1'b1, 8'h81}) $display("FAIL ar_body got %b/%h exp 1/81", flit_vld, flit_data); else pass_cnt++;
    rst_ni = 1'b0; #1;
    total_cnt++; if ({flit_vld, flit_data} !== {1'b0, 8'h00}) $display("FAIL ar_async got %b/%h exp 0/00", flit_vld, flit_data); else pass_cnt++;
    step(); rst_ni = 1'b1; #1;
    total_cnt++; if ({pkt_rdy, pl_rdy} !== 2'b10) $display("FAIL ar_rdy got %b exp 10", {pkt_rdy, pl_rdy}); else pass_cnt++;
    pkt_dst_row = 2'd0; pkt_dst_col = 2'd1; pkt_len = 4'd1; pkt_vld = 1'b1;
    step(); pkt_vld = 1'b0; pl_vld = 1'b1; pl_data = 6'h3C; #1;
    total_cnt++; if ({flit_vld, flit_data} !== {1'b1, 8'h41}) $display("FAIL ar_head got %b/%h exp 1/41", flit_vld, flit_data); else pass_cnt++;
    step(); pl_vld = 1'b0; #1;
    total_cnt++; if ({flit_vld, flit_data} !== {1'b1, 8'hFC}) $display("FAIL ar_tail got %b/%h exp 1/fc", flit_vld, flit_data); else pass_cnt++;
    step();
  endtask

`ifdef NOC_PKTZ_STATS_EN
  task automatic test_stats();
    rst_ni = 1'b0; #1;
    total_cnt++; if ({pkt_cnt, flit_cnt} !== 32'h0) $display("FAIL st_reset got %h/%h exp 0/0", pkt_cnt, flit_cnt); else pass_cnt++;
    step(); rst_ni = 1'b1;
    for (int p = 0; p < 3; p++) begin
      step(); pkt_dst_row = 2'd1; pkt_dst_col = 2'd0; pkt_len = 4'd2; pkt_vld = 1'b1; pl_vld = 1'b0;
      step(); pkt_vld = 1'b0; pl_vld = 1'b1; pl_data = 6'h05;
      step(); pl_data = 6'h06;
    end
    step(); pl_vld = 1'b0;
    step(); step(); #1;
    total_cnt++; if (pkt_cnt !== 16'd3) $display("FAIL st_pkt got %0d exp 3", pkt_cnt); else pass_cnt++;
    total_cnt++; if (flit_cnt !== 16'd9) $display("FAIL st_flit got %0d exp 9", flit_cnt); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_back_to_back();
    test_max_len();
    test_async_reset();
`ifdef NOC_PKTZ_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
